// File: rtl/if_fetch_pkg.sv
// Shared widths, reset PC and fetch-state encodings for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int MEM_ADDR_W  = 18;
  localparam int MEM_VALUE_W = 16;

  localparam logic [MEM_ADDR_W-1:0] RESET_PC_DEF = '0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, drives the RAM2 controller's instruction port and
// hands one instruction at a time to IF/ID. IF_STAT_EN adds fetch/wait counters.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = MEM_ADDR_W,
  parameter int                DATA_W   = MEM_VALUE_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              id_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef IF_STAT_EN
  ,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       wait_cnt
`endif
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              seen_low;
  logic              kill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      mem_req    <= 1'b0;
      mem_addr   <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      seen_low   <= 1'b0;
      kill       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          mem_addr <= redirect ? redirect_pc : pc;
          if (redirect) pc <= redirect_pc;
          mem_req  <= 1'b1;
          seen_low <= 1'b0;
          state    <= ST_REQ;
        end
        // mem_done may still be high from the previous fetch; only a low
        // level proves the controller has taken this request.
        ST_REQ: begin
          if (!mem_done) begin
            seen_low <= 1'b1;
            state    <= ST_WAIT;
          end
          if (redirect) begin
            kill <= 1'b1;
            pc   <= redirect_pc;
          end
        end
        ST_WAIT: begin
          if (!mem_done) seen_low <= 1'b1;
          if (mem_done && seen_low) begin
            mem_req <= 1'b0;
            if (kill || redirect) begin
              kill  <= 1'b0;
              state <= ST_IDLE;
              if (redirect) pc <= redirect_pc;
            end else begin
              inst       <= mem_data;
              inst_pc    <= mem_addr;
              inst_valid <= 1'b1;
              pc         <= mem_addr + ADDR_W'(1);
              state      <= ST_HOLD;
            end
          end else if (redirect) begin
            kill <= 1'b1;
            pc   <= redirect_pc;
          end
        end
        ST_HOLD: begin
          // A redirect wins over a same-cycle id_ready: the held instruction is dropped.
          if (redirect) begin
            inst_valid <= 1'b0;
            pc         <= redirect_pc;
            state      <= ST_IDLE;
          end else if (id_ready) begin
            inst_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IF_STAT_EN
  logic xfer;
  assign xfer = (state == ST_HOLD) && inst_valid && id_ready && !redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (xfer)    fetch_cnt <= fetch_cnt + 16'd1;
      if (mem_req) wait_cnt  <= wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: two instances (RESET_PC 0 and 3FFFF) behind a
// small RAM2 controller model with a divide-by-2 decision slot.
module tb_if_fetch;

  logic              clk, rst;
  logic [1:0]        mem_req, mem_done, inst_valid, id_ready, redirect;
  logic [17:0]       mem_addr [2];
  logic [15:0]       mem_data [2];
  logic [15:0]       inst     [2];
  logic [17:0]       inst_pc  [2];
  logic [17:0]       redirect_pc [2];
  logic              exe_req;
`ifdef IF_STAT_EN
  logic [15:0]       fetch_cnt [2];
  logic [15:0]       wait_cnt  [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [17:0] qa0[$], qa1[$];
  logic [33:0] qi0[$], qi1[$];

  if_fetch #(.ADDR_W(18), .DATA_W(16), .RESET_PC(18'h0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_req(mem_req[0]), .mem_addr(mem_addr[0]),
    .mem_done(mem_done[0]), .mem_data(mem_data[0]), .inst_valid(inst_valid[0]),
    .inst(inst[0]), .inst_pc(inst_pc[0]), .id_ready(id_ready[0]),
    .redirect(redirect[0]), .redirect_pc(redirect_pc[0])
`ifdef IF_STAT_EN
    , .fetch_cnt(fetch_cnt[0]), .wait_cnt(wait_cnt[0])
`endif
  );

  if_fetch #(.ADDR_W(18), .DATA_W(16), .RESET_PC(18'h3FFFF)) u_dut1 (
    .clk(clk), .rst(rst), .mem_req(mem_req[1]), .mem_addr(mem_addr[1]),
    .mem_done(mem_done[1]), .mem_data(mem_data[1]), .inst_valid(inst_valid[1]),
    .inst(inst[1]), .inst_pc(inst_pc[1]), .id_ready(id_ready[1]),
    .redirect(redirect[1]), .redirect_pc(redirect_pc[1])
`ifdef IF_STAT_EN
    , .fetch_cnt(fetch_cnt[1]), .wait_cnt(wait_cnt[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- controller model ----------------
  function automatic logic [15:0] mem_word(input logic [17:0] a);
    if (a == 18'h0) return 16'h0800;
    return 16'hC000 | {2'b00, a[13:0]};
  endfunction

  logic        div;
  logic [1:0]  busy;
  logic [2:0]  cnt [2];
  logic [17:0] lat [2];
  logic [4:0]  exe_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      div      <= 1'b0;
      busy     <= 2'b00;
      exe_cnt  <= 5'd0;
      mem_done <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        cnt[k]      <= 3'd0;
        lat[k]      <= 18'h0;
        mem_data[k] <= 16'h0;
      end
    end else begin
      div <= ~div;
      if (exe_cnt != 5'd0) exe_cnt <= exe_cnt - 5'd1;
      for (int k = 0; k < 2; k++) begin
        if (k == 0 && exe_cnt != 5'd0) begin
          // execute port owns the controller
        end else if (busy[k]) begin
          if (cnt[k] == 3'd1) begin
            busy[k]     <= 1'b0;
            mem_done[k] <= 1'b1;
            mem_data[k] <= mem_word(lat[k]);
          end else cnt[k] <= cnt[k] - 3'd1;
        end else if (k == 0 && div && exe_req) begin
          exe_cnt <= 5'd20;
        end else if (div && mem_req[k]) begin
          busy[k]     <= 1'b1;
          cnt[k]      <= 3'd4;
          mem_done[k] <= 1'b0;
          lat[k]      <= mem_addr[k];
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_launch(input int k);
    logic [17:0] e;
    if ((k == 0 ? qa0.size() : qa1.size()) == 0) begin
      n_tests++; n_fail++;
      $display("FAIL launch%0d: got fetch at %h required no fetch", k, mem_addr[k]);
    end else begin
      e = (k == 0) ? qa0.pop_front() : qa1.pop_front();
      chk($sformatf("launch%0d_addr", k), 64'(mem_addr[k]), 64'(e));
    end
  endtask

  task automatic check_xfer(input int k);
    logic [33:0] e;
    if ((k == 0 ? qi0.size() : qi1.size()) == 0) begin
      n_tests++; n_fail++;
      $display("FAIL xfer%0d: got inst %h pc %h required no transfer", k, inst[k], inst_pc[k]);
    end else begin
      e = (k == 0) ? qi0.pop_front() : qi1.pop_front();
      chk($sformatf("xfer%0d_inst_pc", k), 64'({inst[k], inst_pc[k]}), 64'(e));
    end
  endtask

  logic [1:0] req_prev;
  always @(negedge clk) begin
    if (!rst) req_prev <= 2'b00;
    else begin
      for (int k = 0; k < 2; k++) begin
        if (mem_req[k] && !req_prev[k]) check_launch(k);
        if (inst_valid[k] && id_ready[k] && !redirect[k]) check_xfer(k);
      end
      req_prev <= mem_req;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_addr(input int k, input logic [17:0] a);
    if (k == 0) qa0.push_back(a); else qa1.push_back(a);
  endtask

  task automatic push_inst(input int k, input logic [17:0] pc, input logic [15:0] w);
    if (k == 0) qi0.push_back({w, pc}); else qi1.push_back({w, pc});
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int k);
    for (int i = 0; i < 200; i++) begin
      if (inst_valid[k]) return;
      step();
    end
    n_tests++; n_fail++;
    $display("FAIL wait_valid%0d: got timeout required inst_valid", k);
  endtask

  task automatic xfer(input int k);
    id_ready[k] = 1'b1;
    step();
    id_ready[k] = 1'b0;
  endtask

  task automatic fetch_xfer(input int k, input logic [17:0] pc, input logic [15:0] w,
                            input logic [17:0] nxt);
    push_inst(k, pc, w);
    wait_valid(k);
    push_addr(k, nxt);
    xfer(k);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0; id_ready = 2'b00; redirect = 2'b00; exe_req = 1'b0;
    redirect_pc[0] = 18'h0; redirect_pc[1] = 18'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dut0", 64'({mem_req[0], mem_addr[0], inst_valid[0], inst[0], inst_pc[0]}), 64'h0);
    chk("reset_dut1_addr", 64'({mem_req[1], mem_addr[1], inst_valid[1]}), 64'({1'b0, 18'h3FFFF, 1'b0}));
`ifdef IF_STAT_EN
    chk("reset_cnt", 64'({fetch_cnt[0], wait_cnt[0]}), 64'h0);
`endif
    push_addr(0, 18'h0);
    push_addr(1, 18'h3FFFF);
    rst = 1'b1;
    step();
    chk("first_req_dut0", 64'({mem_req[0], mem_addr[0]}), 64'({1'b1, 18'h0}));
    chk("first_req_dut1", 64'({mem_req[1], mem_addr[1]}), 64'({1'b1, 18'h3FFFF}));

    // first instruction held while ID stalls
    push_inst(0, 18'h0, 16'h0800);
    wait_valid(0);
    for (int i = 0; i < 10; i++) begin
      chk("hold_stable", 64'({inst_valid[0], mem_req[0], inst[0], inst_pc[0]}),
          64'({1'b1, 1'b0, 16'h0800, 18'h0}));
      step();
    end
    push_addr(0, 18'h1);
    xfer(0);
    fetch_xfer(0, 18'h1, 16'hC001, 18'h2);
    fetch_xfer(0, 18'h2, 16'hC002, 18'h3);
    fetch_xfer(0, 18'h3, 16'hC003, 18'h4);
    fetch_xfer(0, 18'h4, 16'hC004, 18'h5);

    // redirect while the fetch at 5 is in flight
    for (int i = 0; i < 100 && !(mem_req[0] && mem_addr[0] == 18'h5 && !mem_done[0]); i++) step();
    step();
    push_addr(0, 18'h100);
    redirect[0] = 1'b1; redirect_pc[0] = 18'h100;
    step();
    redirect[0] = 1'b0;
    for (int i = 0; i < 50 && !mem_done[0]; i++) begin
      chk("kill_req_held", 64'(mem_req[0]), 64'h1);
      step();
    end
    step();
    chk("kill_done", 64'({mem_req[0], inst_valid[0]}), 64'h0);
    fetch_xfer(0, 18'h100, 16'hC100, 18'h101);

    // redirect in HOLD beats a same-cycle id_ready
    push_addr(0, 18'h20);
    wait_valid(0);
    chk("hold_pc", 64'(inst_pc[0]), 64'(18'h101));
    redirect[0] = 1'b1; redirect_pc[0] = 18'h20; id_ready[0] = 1'b1;
    step();
    redirect[0] = 1'b0; id_ready[0] = 1'b0;
    chk("hold_redirect_drop", 64'(inst_valid[0]), 64'h0);

    // execute port grabs the controller before the fetch at 0x21
    push_inst(0, 18'h20, 16'hC020);
    wait_valid(0);
    exe_req = 1'b1;
    step(); step();
    exe_req = 1'b0;
    push_addr(0, 18'h21);
    xfer(0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("exe_block", 64'({mem_req[0], inst_valid[0]}), 64'h2);
    end
    fetch_xfer(0, 18'h21, 16'hC021, 18'h22);

    // PC wrap on the RESET_PC=3FFFF instance
    fetch_xfer(1, 18'h3FFFF, 16'hFFFF, 18'h0);
    fetch_xfer(1, 18'h0, 16'h0800, 18'h1);
`ifdef IF_STAT_EN
    chk("fetch_cnt_dut1", 64'(fetch_cnt[1]), 64'd2);
    chk("fetch_cnt_dut0", 64'(fetch_cnt[0]), 64'd8);
`endif

    repeat (10) step();
    chk("queues_drained", 64'({qa0.size(), qa1.size(), qi0.size(), qi1.size()}), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
